// File: rtl/debounce_timer_arbiter.sv
// One delay counter shared round-robin by N_CH debouncer channels.
// A channel requests by holding timer_reset low and gets timer_done after TIMER_TICKS cycles.
module debounce_timer_arbiter #(
    parameter int N_CH        = 4,
    parameter int TIMER_TICKS = 1000000,
    localparam int CW         = $clog2(TIMER_TICKS),
    localparam int IW         = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] timer_reset,
    output logic [N_CH-1:0] timer_done,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_idx,
    output logic [CW-1:0]   busy_cnt
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t          state, state_d;
    logic [IW-1:0]   rr_ptr, rr_d;
    logic [IW-1:0]   gidx, gidx_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [N_CH-1:0] done_q, done_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   nxt_ptr;
    logic            rel;

    // Scan from the farthest offset down so the nearest active index at/after rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = N_CH - 1; off >= 0; off--) begin
            cand = IW'((int'(rr_ptr) + off) % N_CH);
            if (!timer_reset[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign nxt_ptr = (gidx == IW'(N_CH - 1)) ? '0 : gidx + 1'b1;
    assign rel     = timer_reset[gidx];

    always_comb begin
        state_d = state;
        rr_d    = rr_ptr;
        gidx_d  = gidx;
        cnt_d   = cnt;
        done_d  = done_q;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_d = COUNT;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            COUNT: begin
                // Abandon takes priority over terminal count: no done pulse.
                if (rel) begin
                    state_d = IDLE;
                    rr_d    = nxt_ptr;
                end else if (cnt == CW'(TIMER_TICKS - 1)) begin
                    state_d      = DONE;
                    done_d       = '0;
                    done_d[gidx] = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: begin
                if (rel) begin
                    state_d = IDLE;
                    done_d  = '0;
                    rr_d    = nxt_ptr;
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gidx   <= '0;
            cnt    <= '0;
            done_q <= '0;
        end else begin
            state  <= state_d;
            rr_ptr <= rr_d;
            gidx   <= gidx_d;
            cnt    <= cnt_d;
            done_q <= done_d;
        end
    end

    assign timer_done  = done_q;
    assign grant_valid = (state != IDLE);
    assign grant_idx   = gidx;
    assign busy_cnt    = cnt;
endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Directed bench for debounce_timer_arbiter with N_CH = 4, TIMER_TICKS = 8.
module tb_debounce_timer_arbiter;
    localparam int N_CH = 4;
    localparam int TICKS = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] timer_reset;
    logic [3:0] timer_done;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [2:0] busy_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    debounce_timer_arbiter #(.N_CH(N_CH), .TIMER_TICKS(TICKS)) dut (
        .clk        (clk),
        .reset      (reset),
        .timer_reset(timer_reset),
        .timer_done (timer_done),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .busy_cnt   (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_gv"}, 32'(grant_valid), 32'd0);
        check({tag, "_done"}, 32'(timer_done), 32'd0);
    endtask

    initial begin
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        timer_reset = 4'hF;
        reset = 1'b0;
        #3;
        check("rst_done", 32'(timer_done), 32'd0);
        check("rst_gv",   32'(grant_valid), 32'd0);
        check("rst_gidx", 32'(grant_idx), 32'd0);
        check("rst_cnt",  32'(busy_cnt), 32'd0);
        do_reset();
        step();

        // 1: single channel full interval
        timer_reset = 4'b1101;
        step();
        check("s1_gv",   32'(grant_valid), 32'd1);
        check("s1_gidx", 32'(grant_idx), 32'd1);
        check("s1_cnt0", 32'(busy_cnt), 32'd0);
        step(7);
        check("s1_cnt7", 32'(busy_cnt), 32'd7);
        check("s1_nodone", 32'(timer_done), 32'd0);
        step();
        check("s1_done", 32'(timer_done), 32'b0010);
        step(2);
        check("s1_hold", 32'(timer_done), 32'b0010);
        check("s1_cnthold", 32'(busy_cnt), 32'd7);
        timer_reset = 4'hF;
        step();
        chk_idle("s1_rel");

        // 3: ch3 abandons at cnt 4 (rr_ptr was 2), then restarts from 0
        timer_reset = 4'b0111;
        step();
        check("s3_gidx", 32'(grant_idx), 32'd3);
        step(4);
        check("s3_cnt4", 32'(busy_cnt), 32'd4);
        timer_reset = 4'hF;
        step();
        chk_idle("s3_ab");
        timer_reset = 4'b0111;
        step();
        check("s3_regrant", 32'(grant_idx), 32'd3);
        check("s3_cnt0", 32'(busy_cnt), 32'd0);
        timer_reset = 4'hF;
        step();
        chk_idle("s3_ab2");

        // 2: ch0 and ch2 together with rr_ptr = 0
        timer_reset = 4'b1010;
        step();
        check("s2_gidx0", 32'(grant_idx), 32'd0);
        step(8);
        check("s2_done0", 32'(timer_done), 32'b0001);
        step();
        check("s2_hold0", 32'(timer_done), 32'b0001);
        timer_reset = 4'b1011;
        step();
        chk_idle("s2_rel0");
        step();
        check("s2_gidx2", 32'(grant_idx), 32'd2);
        check("s2_cnt0", 32'(busy_cnt), 32'd0);
        step(7);
        check("s2_nodone2", 32'(timer_done), 32'd0);
        step();
        check("s2_done2", 32'(timer_done), 32'b0100);
        timer_reset = 4'hF;
        step();
        chk_idle("s2_rel2");

        // 4: abandon on the terminal-count edge (rr_ptr = 3, only ch1 active)
        timer_reset = 4'b1101;
        step();
        check("s4_gidx", 32'(grant_idx), 32'd1);
        step(7);
        check("s4_cnt7", 32'(busy_cnt), 32'd7);
        timer_reset = 4'hF;
        step();
        chk_idle("s4_ab");
        step();
        check("s4_done", 32'(timer_done), 32'd0);

        // 6: async reset mid-COUNT (rr_ptr = 2 before reset)
        timer_reset = 4'b1011;
        step();
        check("s6_gidx", 32'(grant_idx), 32'd2);
        step(5);
        check("s6_cnt5", 32'(busy_cnt), 32'd5);
        #2 reset = 1'b0;
        #1;
        check("s6_rgv",   32'(grant_valid), 32'd0);
        check("s6_rcnt",  32'(busy_cnt), 32'd0);
        check("s6_rgidx", 32'(grant_idx), 32'd0);
        check("s6_rdone", 32'(timer_done), 32'd0);
        timer_reset = 4'b1001;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step();
        check("s6_regrant", 32'(grant_idx), 32'd1);
        check("s6_gv", 32'(grant_valid), 32'd1);
        timer_reset = 4'hF;
        do_reset();

        // 5: all channels request continuously, release right after done
        timer_reset = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("s5_gidx%0d", k), 32'(grant_idx), 32'(order[k]));
            check($sformatf("s5_gv%0d", k), 32'(grant_valid), 32'd1);
            step(8);
            check($sformatf("s5_done%0d", k), 32'(timer_done), 32'(4'b0001 << order[k]));
            timer_reset[order[k]] = 1'b1;
            step();
            check($sformatf("s5_idle%0d", k), 32'(grant_valid), 32'd0);
            timer_reset[order[k]] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
